// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared constants and state encoding for the instruction-memory loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int LEN_W          = 16;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LEN_HI  = 4'd1;
  localparam logic [3:0] ST_LEN_LO  = 4'd2;
  localparam logic [3:0] ST_DATA_HI = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_WRITE   = 4'd5;
  localparam logic [3:0] ST_CHK     = 4'd6;
  localparam logic [3:0] ST_DONE    = 4'd7;
  localparam logic [3:0] ST_ERROR   = 4'd8;

  // A word count must be non-zero and must fit in a 2^addr_w deep memory.
  function automatic logic len_invalid(input logic [LEN_W-1:0] len, input int unsigned addr_w);
    logic [LEN_W:0] max_len;
    max_len = (LEN_W+1)'(1) << addr_w;
    return (len == '0) || ({1'b0, len} > max_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module : program_loader
// Brief  : Loads the 16-bit instruction memory from an 8-bit byte stream and
//          holds the CPU in reset until a complete image has been written.
//          Optional trailing XOR checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  logic [3:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_hold;
  logic              r_error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        r_chk;
`endif

  logic w_accept;
  logic w_last;

  assign w_accept = in_valid && in_ready;
  // The address register doubles as the word index of the current write.
  assign w_last   = (LEN_W'(r_addr) == r_len - LEN_W'(1));

  assign in_ready   = (r_state == ST_LEN_HI)  || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO) ||
                      (r_state == ST_CHK);
  assign imem_we    = (r_state == ST_WRITE);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign error      = r_error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_error <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_chk   <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LEN_HI;
            r_error <= 1'b0;
            r_hold  <= 1'b1;
            r_addr  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_chk   <= 8'h00;
`endif
          end
        end
        ST_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= in_byte;
            r_state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= in_byte;
            if (len_invalid({r_len[15:8], in_byte}, ADDR_W)) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (w_accept) begin
            r_wdata[15:8] <= in_byte;
            r_state       <= ST_DATA_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_chk         <= r_chk ^ in_byte;
`endif
          end
        end
        ST_DATA_LO: begin
          if (w_accept) begin
            r_wdata[7:0] <= in_byte;
            r_state      <= ST_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_chk        <= r_chk ^ in_byte;
`endif
          end
        end
        ST_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (w_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_state <= ST_CHK;
`else
            // Release is registered on entry so cpu_hold drops in the DONE cycle.
            r_state <= ST_DONE;
            r_hold  <= 1'b0;
`endif
          end else begin
            r_state <= ST_DATA_HI;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_accept) begin
            if (in_byte == r_chk) begin
              r_state <= ST_DONE;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        ST_ERROR: begin
          r_state <= ST_IDLE;
          r_hold  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module : tb_program_loader
// Brief  : Scoreboard bench for program_loader; expected writes are queued as
//          bytes are driven and popped when imem_we is observed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [15:0]              img_q[$];

  // Write monitor: every imem_we cycle must match the next queued write.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (imem_we) begin
      logic [ADDR_W+DATA_W-1:0] e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   imem_addr, imem_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (!in_ready) begin
      if (n >= 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL idle_timeout: busy=%0b, required 0", busy);
    end
  endtask

  // Sends length, img_q words and (if enabled) checksum; queues expected writes.
  task automatic load_image(input logic [15:0] len, input logic bad_chk);
    logic [7:0] chk;
    chk = 8'h00;
    pulse_start();
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < img_q.size(); i++) begin
      exp_q.push_back({ADDR_W'(i), img_q[i]});
      send_byte(img_q[i][15:8]);
      send_byte(img_q[i][7:0]);
      chk = chk ^ img_q[i][15:8] ^ img_q[i][7:0];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (chk ^ 8'h01) : chk);
`else
    if (bad_chk) chk = 8'h00;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, imem_we, cpu_hold, busy, done, error} !== 6'b001000) begin
      failures++;
      $display("FAIL reset_outputs: got rdy/we/hold/busy/done/err=%b, required 001000",
               {in_ready, imem_we, cpu_hold, busy, done, error});
    end
    checks++;
    if ({imem_addr, imem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_addr_data: got %0h/%0h, required 0/0", imem_addr, imem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    img_q.delete();
    img_q.push_back(16'h1234);
    img_q.push_back(16'hABCD);
    load_image(16'd2, 1'b0);
    checks++;
    if (wr_cnt - w0 !== 2) begin
      failures++;
      $display("FAIL basic_writes: got %0d, required 2", wr_cnt - w0);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
    end
    checks++;
    if ({cpu_hold, error} !== 2'b00) begin
      failures++;
      $display("FAIL basic_hold_err: got %b, required 00", {cpu_hold, error});
    end
  endtask

  task automatic test_bad_length();
    logic [15:0] lens[2];
    lens[0] = 16'h0000;
    lens[1] = 16'h0101;
    for (int k = 0; k < 2; k++) begin
      int w0, d0;
      w0 = wr_cnt; d0 = done_cnt;
      pulse_start();
      send_byte(lens[k][15:8]);
      send_byte(lens[k][7:0]);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      checks++;
      if ({error, cpu_hold} !== 2'b11) begin
        failures++;
        $display("FAIL badlen_%0d_err_hold: got %b, required 11", k, {error, cpu_hold});
      end
      checks++;
      if ((wr_cnt - w0) !== 0 || (done_cnt - d0) !== 0) begin
        failures++;
        $display("FAIL badlen_%0d_activity: got writes=%0d done=%0d, required 0/0",
                 k, wr_cnt - w0, done_cnt - d0);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] bytes[4];
    logic [7:0] extra;
    int w0, d0, consumed;
    bytes[0] = 8'h00; bytes[1] = 8'h01; bytes[2] = 8'hDE; bytes[3] = 8'hAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    extra = 8'hDE ^ 8'hAD;
`else
    extra = 8'h55;
`endif
    w0 = wr_cnt; d0 = done_cnt;
    exp_q.push_back({ADDR_W'(0), 16'hDEAD});
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      if (i < 3) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    @(negedge clk);
    in_byte  = extra;
    checks++;
    if ({imem_we, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL stall_write_cycle: got we/rdy=%b, required 10", {imem_we, in_ready});
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(extra);
    @(negedge clk);
    in_valid = 1'b0;
    consumed = 0;
`else
    in_valid = 1'b1;
    consumed = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) consumed++;
    end
    in_valid = 1'b0;
`endif
    wait_idle();
    checks++;
    if (consumed !== 0) begin
      failures++;
      $display("FAIL stall_extra_consumed: got %0d cycles ready, required 0", consumed);
    end
    checks++;
    if ((wr_cnt - w0) !== 1 || (done_cnt - d0) !== 1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL stall_result: got writes=%0d done=%0d hold=%b, required 1/1/0",
               wr_cnt - w0, done_cnt - d0, cpu_hold);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_cnt;
    exp_q.push_back({ADDR_W'(0), 16'h1122});
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, cpu_hold, in_ready, imem_we} !== 4'b0100) begin
      failures++;
      $display("FAIL midreset_state: got busy/hold/rdy/we=%b, required 0100",
               {busy, cpu_hold, in_ready, imem_we});
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      failures++;
      $display("FAIL midreset_writes: got %0d, required 1", wr_cnt - w0);
    end
    img_q.delete();
    for (int i = 0; i < 4; i++) img_q.push_back(16'hA000 + 16'(i * 16'h0111));
    load_image(16'd4, 1'b0);
    checks++;
    if ({cpu_hold, error, exp_q.size() == 0} !== 3'b001) begin
      failures++;
      $display("FAIL midreset_reload: got hold/err/drained=%b, required 001",
               {cpu_hold, error, exp_q.size() == 0});
    end
  endtask

  task automatic test_max_len();
    int w0;
    w0 = wr_cnt;
    img_q.delete();
    for (int i = 0; i < 256; i++) img_q.push_back(16'((i * 16'h0101) ^ 16'h5A3C));
    load_image(16'h0100, 1'b0);
    checks++;
    if (wr_cnt - w0 !== 256 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL maxlen: got writes=%0d hold=%b err=%b, required 256/0/0",
               wr_cnt - w0, cpu_hold, error);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    img_q.delete();
    img_q.push_back(16'h1234);
    d0 = done_cnt;
    load_image(16'd1, 1'b0);
    checks++;
    if ((done_cnt - d0) !== 1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL chk_good: got done=%0d hold=%b err=%b, required 1/0/0",
               done_cnt - d0, cpu_hold, error);
    end
    d0 = done_cnt;
    load_image(16'd1, 1'b1);
    checks++;
    if ((done_cnt - d0) !== 0 || cpu_hold !== 1'b1 || error !== 1'b1) begin
      failures++;
      $display("FAIL chk_bad: got done=%0d hold=%b err=%b, required 0/1/1",
               done_cnt - d0, cpu_hold, error);
    end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    test_reset();
    test_basic();
    test_bad_length();
    test_stall();
    test_reset_mid();
    test_max_len();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
